// File: rtl/exec_pkg.sv
// Shared definitions for the multi-cycle execute unit: opcodes, FSM state encoding and defaults.
package exec_pkg;

    localparam int DEF_WIDTH    = 32;
    localparam int DEF_REG_BITS = 5;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_NOR   = 4'd5;
    localparam logic [3:0] OP_SLT   = 4'd6;
    localparam logic [3:0] OP_SLL   = 4'd7;
    localparam logic [3:0] OP_SRL   = 4'd8;
    localparam logic [3:0] OP_SRA   = 4'd9;
    localparam logic [3:0] OP_MULLO = 4'd10;
    localparam logic [3:0] OP_DIVU  = 4'd11;
    localparam logic [3:0] OP_REMU  = 4'd12;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    typedef enum logic [1:0] {
        MD_MUL  = 2'd0,
        MD_DIVU = 2'd1,
        MD_REMU = 2'd2
    } mdOp_e;

    function automatic logic isMultiCycle(input logic [3:0] op);
        return (op == OP_MULLO) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

    function automatic mdOp_e toMdOp(input logic [3:0] op);
        case (op)
            OP_DIVU: return MD_DIVU;
            OP_REMU: return MD_REMU;
            default: return MD_MUL;
        endcase
    endfunction

endpackage

// File: rtl/exec_unit_mc_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle.
// The first iteration is folded into the start cycle so a result is ready WIDTH-1 cycles later.
module muldiv_iter
    import exec_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  mdOp_e            mdOp,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);

    logic             active;
    logic [CW-1:0]    stepCnt;
    mdOp_e            kind;
    logic [WIDTH-1:0] accRem;
    logic [WIDTH-1:0] mcandDiv;
    logic [WIDTH-1:0] mplierQuo;

    mdOp_e            srcKind;
    logic [WIDTH-1:0] srcA;
    logic [WIDTH-1:0] srcB;
    logic [WIDTH-1:0] srcC;
    logic [WIDTH-1:0] nxtA;
    logic [WIDTH-1:0] nxtB;
    logic [WIDTH-1:0] nxtC;
    logic [WIDTH:0]   shifted;
    logic             qBit;

    // A = accumulator / partial remainder, B = multiplicand / divisor, C = multiplier / dividend-quotient
    always_comb begin
        if (start) begin
            srcKind = mdOp;
            srcA    = '0;
            srcB    = (mdOp == MD_MUL) ? opA : opB;
            srcC    = (mdOp == MD_MUL) ? opB : opA;
        end else begin
            srcKind = kind;
            srcA    = accRem;
            srcB    = mcandDiv;
            srcC    = mplierQuo;
        end

        shifted = {srcA, srcC[WIDTH-1]};
        qBit    = (shifted >= {1'b0, srcB});

        if (srcKind == MD_MUL) begin
            nxtA = srcA + (srcC[0] ? srcB : '0);
            nxtB = srcB << 1;
            nxtC = srcC >> 1;
        end else begin
            // A zero divisor always "fits": quotient fills with ones, remainder ends as the dividend.
            nxtA = qBit ? (shifted[WIDTH-1:0] - srcB) : shifted[WIDTH-1:0];
            nxtB = srcB;
            nxtC = {srcC[WIDTH-2:0], qBit};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active    <= 1'b0;
            stepCnt   <= '0;
            kind      <= MD_MUL;
            accRem    <= '0;
            mcandDiv  <= '0;
            mplierQuo <= '0;
        end else if (start) begin
            active    <= 1'b1;
            stepCnt   <= CW'(WIDTH - 1);
            kind      <= mdOp;
            accRem    <= nxtA;
            mcandDiv  <= nxtB;
            mplierQuo <= nxtC;
        end else if (active) begin
            if (stepCnt == '0) begin
                active <= 1'b0;
            end else begin
                stepCnt   <= stepCnt - CW'(1);
                accRem    <= nxtA;
                mcandDiv  <= nxtB;
                mplierQuo <= nxtC;
            end
        end
    end

    assign done   = active && (stepCnt == '0);
    assign result = (kind == MD_DIVU) ? mplierQuo : accRem;

endmodule

// File: rtl/exec_unit_mc.sv
// Execute stage with operand forwarding, single-cycle ALU, branch resolution
// and an iterative multiply/divide path behind a valid/ready handshake.
//
//   state | meaning
//   IDLE  | accepting; single-cycle results written on the accept edge
//   BUSY  | multiply/divide iterating, input stalled
//   HOLD  | multi-cycle result valid, waiting for out_ready
module exec_unit_mc
    import exec_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int REG_BITS = DEF_REG_BITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    rd1,
    input  logic [WIDTH-1:0]    rd2,
    input  logic [WIDTH-1:0]    imm,
    input  logic [WIDTH-1:0]    pc,
    input  logic [REG_BITS-1:0] rs,
    input  logic [REG_BITS-1:0] rt,
    input  logic [REG_BITS-1:0] rd,
    input  logic                alu_src,
    input  logic [3:0]          op,
    input  logic                branch,
    input  logic                reg_write,
    input  logic [REG_BITS-1:0] mem_rd,
    input  logic                mem_wr,
    input  logic [WIDTH-1:0]    mem_res,
    input  logic [REG_BITS-1:0] wb_rd,
    input  logic                wb_wr,
    input  logic [WIDTH-1:0]    wb_val,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_res,
    output logic [REG_BITS-1:0] out_rd,
    output logic                out_wr,
    output logic                pc_src,
    output logic [WIDTH-1:0]    br_target,
    output logic                flush
);

    localparam int SHW = $clog2(WIDTH);

    logic [1:0]          state;
    logic [SHW-1:0]      busyCnt;
    logic [REG_BITS-1:0] pendRd;
    logic                pendWr;

    logic [WIDTH-1:0]    op1;
    logic [WIDTH-1:0]    op2Reg;
    logic [WIDTH-1:0]    op2;
    logic [SHW-1:0]      shamt;
    logic [WIDTH-1:0]    aluRes;

    logic                accept;
    logic                isMulti;
    logic                isBranch;
    logic                brTaken;
    logic                mdDone;
    logic [WIDTH-1:0]    mdResult;

    // Held low while reset is asserted even though the state already reads IDLE.
    assign in_ready = rst_n && (state == ST_IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign isMulti  = isMultiCycle(op);
    assign isBranch = branch && (op == OP_SUB);
    assign brTaken  = isBranch && (aluRes == '0);

    always_comb begin
        if (mem_wr && (mem_rd == rs) && (rs != '0)) begin
            op1 = mem_res;
        end else if (wb_wr && (wb_rd == rs) && (rs != '0)) begin
            op1 = wb_val;
        end else begin
            op1 = rd1;
        end

        if (mem_wr && (mem_rd == rt) && (rt != '0)) begin
            op2Reg = mem_res;
        end else if (wb_wr && (wb_rd == rt) && (rt != '0)) begin
            op2Reg = wb_val;
        end else begin
            op2Reg = rd2;
        end

        op2   = alu_src ? imm : op2Reg;
        shamt = op2[SHW-1:0];
    end

    always_comb begin
        aluRes = '0;
        case (op)
            OP_ADD:  aluRes = op1 + op2;
            OP_SUB:  aluRes = op1 - op2;
            OP_AND:  aluRes = op1 & op2;
            OP_OR:   aluRes = op1 | op2;
            OP_XOR:  aluRes = op1 ^ op2;
            OP_NOR:  aluRes = ~(op1 | op2);
            OP_SLT:  aluRes = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
            OP_SLL:  aluRes = op1 << shamt;
            OP_SRL:  aluRes = op1 >> shamt;
            OP_SRA:  aluRes = $unsigned($signed(op1) >>> shamt);
            default: aluRes = '0;
        endcase
    end

    muldiv_iter #(
        .WIDTH(WIDTH)
    ) uMulDiv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (accept && isMulti),
        .mdOp  (toMdOp(op)),
        .opA   (op1),
        .opB   (op2),
        .done  (mdDone),
        .result(mdResult)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            busyCnt   <= '0;
            pendRd    <= '0;
            pendWr    <= 1'b0;
            out_valid <= 1'b0;
            out_res   <= '0;
            out_rd    <= '0;
            out_wr    <= 1'b0;
            pc_src    <= 1'b0;
            flush     <= 1'b0;
            br_target <= '0;
        end else begin
            pc_src <= 1'b0;
            flush  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept && isMulti) begin
                        state     <= ST_BUSY;
                        busyCnt   <= SHW'(WIDTH - 1);
                        pendRd    <= rd;
                        pendWr    <= reg_write;
                        out_valid <= 1'b0;
                    end else if (accept) begin
                        out_valid <= 1'b1;
                        out_res   <= aluRes;
                        out_rd    <= rd;
                        out_wr    <= reg_write && !isBranch;
                        if (brTaken) begin
                            pc_src    <= 1'b1;
                            flush     <= 1'b1;
                            br_target <= pc + (imm << 2);
                        end
                    end else if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (busyCnt != '0) begin
                        busyCnt <= busyCnt - SHW'(1);
                    end else if (mdDone) begin
                        out_res   <= mdResult;
                        out_rd    <= pendRd;
                        out_wr    <= pendWr;
                        out_valid <= 1'b1;
                        state     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_unit_mc.sv
// Self-checking bench for exec_unit_mc: directed vector table, multi-cycle corner sequences,
// and randomized traffic scored against a transaction-level reference model.
module tb_exec_unit_mc;
    import exec_pkg::*;

    localparam int W  = 32;
    localparam int RB = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready;
    logic [W-1:0]  rd1, rd2, imm, pc;
    logic [RB-1:0] rs, rt, rd;
    logic          alu_src;
    logic [3:0]    op;
    logic          branch, reg_write;
    logic [RB-1:0] mem_rd;
    logic          mem_wr;
    logic [W-1:0]  mem_res;
    logic [RB-1:0] wb_rd;
    logic          wb_wr;
    logic [W-1:0]  wb_val;
    logic          out_valid, out_ready;
    logic [W-1:0]  out_res;
    logic [RB-1:0] out_rd;
    logic          out_wr, pc_src, flush;
    logic [W-1:0]  br_target;

    exec_unit_mc #(.WIDTH(W), .REG_BITS(RB)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .rd1(rd1), .rd2(rd2), .imm(imm), .pc(pc), .rs(rs), .rt(rt), .rd(rd),
        .alu_src(alu_src), .op(op), .branch(branch), .reg_write(reg_write),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_res(mem_res),
        .wb_rd(wb_rd), .wb_wr(wb_wr), .wb_val(wb_val),
        .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
        .out_rd(out_rd), .out_wr(out_wr), .pc_src(pc_src),
        .br_target(br_target), .flush(flush)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nErrors = 0;

    typedef struct {
        logic [3:0]    op;
        logic [W-1:0]  a, b, imm;
        logic          src;
        logic [RB-1:0] rs, rt, memRd, wbRd;
        logic          memWr, wbWr;
        logic [W-1:0]  memRes, wbVal, exp;
    } vec_t;

    typedef struct {
        logic [W-1:0]  res;
        logic [RB-1:0] rdIdx;
        logic          wr;
        logic          multi;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        in_valid = 0; rd1 = '0; rd2 = '0; imm = '0; pc = '0;
        rs = 5'd1; rt = 5'd2; rd = 5'd0; alu_src = 0; op = OP_ADD;
        branch = 0; reg_write = 1; mem_rd = '0; mem_wr = 0; mem_res = '0;
        wb_rd = '0; wb_wr = 0; wb_val = '0; out_ready = 1;
    endtask

    function automatic vec_t mkVec(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [W-1:0] e);
        vec_t v;
        v.op = o; v.a = a; v.b = b; v.imm = '0; v.src = 0;
        v.rs = 5'd1; v.rt = 5'd2; v.memRd = 5'd0; v.wbRd = 5'd0;
        v.memWr = 0; v.wbWr = 0; v.memRes = '0; v.wbVal = '0; v.exp = e;
        return v;
    endfunction

    task automatic applyVec(input vec_t v, input logic [RB-1:0] dst);
        op = v.op; rd1 = v.a; rd2 = v.b; imm = v.imm; alu_src = v.src;
        rs = v.rs; rt = v.rt; mem_rd = v.memRd; mem_wr = v.memWr; mem_res = v.memRes;
        wb_rd = v.wbRd; wb_wr = v.wbWr; wb_val = v.wbVal; rd = dst;
        branch = 0; reg_write = 1; in_valid = 1;
    endtask

    // Reference model: forwarding priority and operation semantics in plain arithmetic.
    function automatic logic [W-1:0] fwdVal(input logic [RB-1:0] idx, input logic [W-1:0] regVal);
        if (idx != 0 && mem_wr && mem_rd == idx) return mem_res;
        if (idx != 0 && wb_wr && wb_rd == idx) return wb_val;
        return regVal;
    endfunction

    function automatic logic [W-1:0] refOp(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] prod;
        case (o)
            OP_ADD:   return a + b;
            OP_SUB:   return a - b;
            OP_AND:   return a & b;
            OP_OR:    return a | b;
            OP_XOR:   return a ^ b;
            OP_NOR:   return ~(a | b);
            OP_SLT:   return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            OP_SLL:   return a << b[4:0];
            OP_SRL:   return a >> b[4:0];
            OP_SRA:   return W'($signed(a) >>> b[4:0]);
            OP_MULLO: begin prod = 64'(a) * 64'(b); return prod[W-1:0]; end
            OP_DIVU:  return (b == 0) ? '1 : a / b;
            OP_REMU:  return (b == 0) ? a : a % b;
            default:  return '0;
        endcase
    endfunction

    function automatic logic [W-1:0] rndVal();
        case ($urandom_range(0, 4))
            0:       return '0;
            1:       return '1;
            2:       return W'($urandom_range(0, 40));
            default: return W'($urandom);
        endcase
    endfunction

    task automatic runMulti(input string name, input logic [3:0] o, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [W-1:0] exp, input int holdCycles);
        int lat;
        int readyBad;
        clearInputs();
        out_ready = (holdCycles == 0);
        op = o; rd1 = a; rd2 = b; rs = 5'd3; rt = 5'd4; rd = 5'd12; in_valid = 1;
        tick();
        // Keep offering an ADD and churn forwarding sources while busy.
        op = OP_ADD; rd1 = 32'h1234; rd2 = 32'h1;
        lat = 0; readyBad = 0;
        while (!out_valid && lat < 200) begin
            if (in_ready) readyBad++;
            mem_wr = 1; mem_rd = 5'd3; mem_res = $urandom;
            wb_wr = 1; wb_rd = 5'd4; wb_val = $urandom;
            tick();
            lat++;
        end
        chk({name, "_latency"}, lat, W);
        chk({name, "_in_ready_busy"}, readyBad, 0);
        chk({name, "_res"}, out_res, exp);
        chk({name, "_rd"}, out_rd, 5'd12);
        chk({name, "_wr"}, out_wr, 1'b1);
        for (int k = 0; k < holdCycles; k++) begin
            chk({name, "_hold_valid"}, out_valid, 1'b1);
            chk({name, "_hold_ready"}, in_ready, 1'b0);
            chk({name, "_hold_res"}, out_res, exp);
            tick();
        end
        in_valid = 0; out_ready = 1;
        tick();
        chk({name, "_drained"}, out_valid, 1'b0);
        chk({name, "_ready_again"}, in_ready, 1'b1);
    endtask

    initial begin
        vec_t v;
        exp_t e;
        logic [W-1:0] a, b, r, expTgt;
        logic isBr, expPc, expReady;
        int lat, stray, pick;

        clearInputs();
        rst_n = 0;
        in_valid = 1; rd1 = 32'd1; rd2 = 32'd2;
        #12;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_res", out_res, '0);
        chk("rst_out_rd", out_rd, '0);
        chk("rst_out_wr", out_wr, 1'b0);
        chk("rst_pc_src", pc_src, 1'b0);
        chk("rst_flush", flush, 1'b0);
        chk("rst_br_target", br_target, '0);
        @(posedge clk); #3;
        rst_n = 1;
        #1;
        chk("rel_in_ready", in_ready, 1'b1);
        in_valid = 0;
        tick(); tick();

        // Directed vector table, issued back to back.
        v = mkVec(OP_ADD, 32'd0, 32'd1, 32'd11);
        v.rs = 5'd3; v.rt = 5'd4; v.memRd = 5'd3; v.memWr = 1; v.memRes = 32'd10;
        v.wbRd = 5'd3; v.wbWr = 1; v.wbVal = 32'd20; vecs.push_back(v);
        v = mkVec(OP_ADD, 32'd5, 32'd0, 32'd7);
        v.rs = 5'd0; v.memRd = 5'd0; v.memWr = 1; v.memRes = 32'd99; v.src = 1; v.imm = 32'd2; vecs.push_back(v);
        v = mkVec(OP_SUB, 32'd100, 32'd3, 32'd47);
        v.rs = 5'd2; v.rt = 5'd6; v.wbRd = 5'd2; v.wbWr = 1; v.wbVal = 32'd50;
        v.memRd = 5'd2; v.memRes = 32'd77; vecs.push_back(v);
        v = mkVec(OP_OR, 32'h100, 32'h55, 32'h10F);
        v.rt = 5'd5; v.memRd = 5'd5; v.memWr = 1; v.memRes = 32'hF0; v.src = 1; v.imm = 32'h0F; vecs.push_back(v);
        vecs.push_back(mkVec(OP_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF));
        vecs.push_back(mkVec(OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1));
        vecs.push_back(mkVec(OP_SLT, 32'd5, 32'hFFFF_FFFE, 32'd0));
        vecs.push_back(mkVec(OP_SRA, 32'h8000_0000, 32'h24, 32'hF800_0000));
        vecs.push_back(mkVec(OP_SRL, 32'h8000_0000, 32'h24, 32'h0800_0000));
        vecs.push_back(mkVec(OP_SLL, 32'd1, 32'd31, 32'h8000_0000));
        vecs.push_back(mkVec(OP_NOR, 32'h0F0F_0000, 32'h0000_F0F0, 32'hF0F0_0F0F));
        vecs.push_back(mkVec(OP_XOR, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'hF0F0_F0F0));
        vecs.push_back(mkVec(OP_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00));
        v = mkVec(OP_ADD, 32'd1, 32'd0, 32'h1001);
        v.rt = 5'd7; v.memRd = 5'd7; v.memWr = 1; v.memRes = 32'h1000;
        v.wbRd = 5'd7; v.wbWr = 1; v.wbVal = 32'd5; vecs.push_back(v);

        clearInputs();
        for (int i = 0; i < vecs.size(); i++) begin
            applyVec(vecs[i], RB'(i + 1));
            tick();
            chk($sformatf("vec%0d_valid", i), out_valid, 1'b1);
            chk($sformatf("vec%0d_res", i), out_res, vecs[i].exp);
            chk($sformatf("vec%0d_rd", i), out_rd, RB'(i + 1));
        end
        in_valid = 0;
        tick();
        chk("vec_drain", out_valid, 1'b0);

        // Taken branch.
        clearInputs();
        op = OP_SUB; rd1 = 32'd7; rd2 = 32'd7; branch = 1; pc = 32'h40; imm = 32'd3; rd = 5'd9; in_valid = 1;
        tick();
        in_valid = 0; branch = 0;
        chk("br_pc_src", pc_src, 1'b1);
        chk("br_flush", flush, 1'b1);
        chk("br_target", br_target, 32'h4C);
        chk("br_out_wr", out_wr, 1'b0);
        tick();
        chk("br_pc_src_pulse", pc_src, 1'b0);
        chk("br_flush_pulse", flush, 1'b0);

        // Not-taken branch.
        op = OP_SUB; rd1 = 32'd7; rd2 = 32'd8; branch = 1; pc = 32'h80; imm = 32'd5; in_valid = 1;
        tick();
        in_valid = 0; branch = 0;
        chk("brnt_pc_src", pc_src, 1'b0);
        chk("brnt_out_wr", out_wr, 1'b0);
        chk("brnt_res", out_res, 32'hFFFF_FFFF);
        tick();

        runMulti("mullo", OP_MULLO, 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 0);
        runMulti("divu0", OP_DIVU, 32'd100, 32'd0, 32'hFFFF_FFFF, 5);
        runMulti("remu0", OP_REMU, 32'd100, 32'd0, 32'd100, 0);
        runMulti("divu", OP_DIVU, 32'd1000, 32'd7, 32'd142, 0);

        // Reset in the middle of a divide.
        clearInputs();
        op = OP_DIVU; rd1 = 32'd1000; rd2 = 32'd7; in_valid = 1;
        tick();
        in_valid = 0;
        repeat (9) tick();
        #2 rst_n = 0;
        #1;
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_ready", in_ready, 1'b0);
        @(posedge clk); #3;
        rst_n = 1;
        #1;
        chk("midrst_rel_ready", in_ready, 1'b1);
        op = OP_ADD; rd1 = 32'd2; rd2 = 32'd3; in_valid = 1; out_ready = 0;
        tick();
        in_valid = 0;
        chk("midrst_add_valid", out_valid, 1'b1);
        chk("midrst_add_res", out_res, 32'd5);
        out_ready = 1;
        tick();
        stray = 0;
        for (int k = 0; k < 40; k++) begin
            if (out_valid) stray++;
            tick();
        end
        chk("midrst_no_partial", stray, 0);

        // Randomized traffic against the transaction-level model.
        clearInputs();
        tick();
        expPc = 0; expTgt = '0;
        for (int c = 0; c < 3000; c++) begin
            in_valid  = (c < 2900) && ($urandom_range(0, 9) < 7);
            out_ready = (c >= 2900) || ($urandom_range(0, 9) < 7);
            pick = $urandom_range(0, 99);
            op = (pick < 9) ? 4'(10 + pick % 3) : 4'($urandom_range(0, 9));
            rd1 = rndVal(); rd2 = rndVal(); imm = rndVal(); pc = $urandom;
            rs = RB'($urandom_range(0, 7)); rt = RB'($urandom_range(0, 7)); rd = RB'($urandom);
            mem_rd = RB'($urandom_range(0, 7)); wb_rd = RB'($urandom_range(0, 7));
            mem_wr = 1'($urandom_range(0, 1)); wb_wr = 1'($urandom_range(0, 1));
            mem_res = rndVal(); wb_val = rndVal();
            alu_src = ($urandom_range(0, 3) == 0);
            branch = ($urandom_range(0, 2) == 0);
            reg_write = 1'($urandom_range(0, 1));
            if (branch && $urandom_range(0, 1) == 1) begin
                mem_wr = 0; wb_wr = 0; alu_src = 0; rd2 = rd1;
            end

            @(negedge clk);
            chk("rnd_pc_src", pc_src, expPc);
            chk("rnd_flush", flush, expPc);
            if (expPc) chk("rnd_br_target", br_target, expTgt);

            if (sb.size() == 0) begin
                expReady = 1;
                chk("rnd_idle_valid", out_valid, 1'b0);
            end else if (sb[0].multi) begin
                expReady = 0;
            end else begin
                expReady = out_ready;
                chk("rnd_single_valid", out_valid, 1'b1);
            end
            chk("rnd_in_ready", in_ready, expReady);

            if (out_valid && out_ready && sb.size() != 0) begin
                e = sb.pop_front();
                chk("rnd_res", out_res, e.res);
                chk("rnd_rd", out_rd, e.rdIdx);
                chk("rnd_wr", out_wr, e.wr);
            end

            expPc = 0;
            if (in_valid && in_ready) begin
                a = fwdVal(rs, rd1);
                b = alu_src ? imm : fwdVal(rt, rd2);
                r = refOp(op, a, b);
                isBr = branch && (op == OP_SUB);
                e.res = r; e.rdIdx = rd; e.wr = reg_write && !isBr;
                e.multi = (op == OP_MULLO) || (op == OP_DIVU) || (op == OP_REMU);
                sb.push_back(e);
                if (isBr && r == 0) begin
                    expPc = 1;
                    expTgt = pc + (imm << 2);
                end
            end
            @(posedge clk); #1;
        end
        chk("rnd_drain", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule

// File: doc/exec_unit_mc.md
EXEC_UNIT_MC -- requirements
Module: exec_unit_mc

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits (legal: 8..64, even).
REQ-002 Parameter REG_BITS, default 5, register-index width.
REQ-003 Ports:
  clk  in  1  single clock, rising edge.
  rst_n  in  1  asynchronous active-low reset.
  in_valid  in  1  issue stage presents an instruction.
  in_ready  out  1  unit accepts when high.
  rd1, rd2  in  WIDTH  register operands.
  imm  in  WIDTH  sign-extended immediate.
  pc  in  WIDTH  incremented PC of the instruction.
  rs, rt, rd  in  REG_BITS  source and destination indices.
  alu_src  in  1  1 = op2 from imm.
  op  in  4  operation code from the shared package.
  branch, reg_write  in  1  control bits.
  mem_rd  in  REG_BITS  EX/MEM destination.
  mem_wr  in  1  EX/MEM register write.
  mem_res  in  WIDTH  EX/MEM result.
  wb_rd  in  REG_BITS  WB destination.
  wb_wr  in  1  WB register write.
  wb_val  in  WIDTH  WB value.
  out_valid  out  1  result register holds a valid instruction.
  out_ready  in  1  downstream accepts.
  out_res  out  WIDTH  result.
  out_rd  out  REG_BITS  destination index.
  out_wr  out  1  destination write enable.
  pc_src  out  1  branch taken, one-cycle pulse.
  br_target  out  WIDTH  branch target.
  flush  out  1  squash younger instructions, same cycle as pc_src.

Function
REQ-004 Forwarding for op1 and op2: if mem_wr and mem_rd == rs/rt and the index is nonzero, use mem_res; else if wb_wr, wb_rd matches and the index is nonzero, use wb_val; else use rd1/rd2.
REQ-005 If alu_src = 1, op2 SHALL be imm regardless of forwarding.
REQ-006 Single-cycle ops: ADD, SUB, AND, OR, XOR, NOR, SLT (signed), SLL/SRL/SRA. The shift amount is op2[log2(WIDTH)-1:0]. Results are written to out_res on the accept edge.
REQ-007 Multi-cycle ops: MULLO (low WIDTH bits, shift-add, one bit per cycle), DIVU and REMU (restoring, one bit per cycle). Each completes WIDTH cycles after acceptance.
REQ-008 FSM states: IDLE, BUSY, HOLD.
  IDLE: a single-cycle op is accepted and out_valid is set. A multi-cycle op is accepted, operands are latched, the counter is set to WIDTH-1, and the state moves to BUSY.
  BUSY: in_ready = 0. When the counter reaches 0, the result is written to out_res, out_valid is set, and the state moves to HOLD.
  HOLD: the result is held until out_ready, then the state returns to IDLE.
REQ-009 in_ready = (state == IDLE) and (out_valid == 0 or out_ready == 1). Acceptance happens on in_valid and in_ready.
REQ-010 out_valid clears on out_valid and out_ready unless a new single-cycle op is accepted in the same cycle; back-to-back single-cycle ops sustain 1 per cycle.
REQ-011 Divide by zero: DIVU returns all ones and REMU returns the dividend, still after WIDTH cycles.
REQ-012 Branch (op = SUB with branch = 1): when the result is zero on acceptance, pc_src and flush pulse high for exactly that one cycle and br_target = pc + (imm << 2), modulo 2^WIDTH. A branch sets out_wr = 0.
REQ-013 Forwarding sources are sampled only at acceptance; forwarding inputs that change during BUSY SHALL NOT affect the latched operands.
REQ-014 Arithmetic wraps modulo 2^WIDTH; there is no overflow trap.

Reset
REQ-015 While rst_n = 0:
  - state = IDLE, counter = 0
  - out_valid = 0, out_res = 0, out_rd = 0, out_wr = 0
  - pc_src = 0, flush = 0, br_target = 0
  - in_ready = 0 during reset and 1 after reset release.
REQ-016 Reset asserted during BUSY abandons the operation; no partial result appears after reset release.

Structure
REQ-017 The op encodings, the FSM state encoding and the default WIDTH SHALL live in the shared package exec_pkg.
REQ-018 The iterative multiply/divide datapath SHALL be one sub-module, muldiv_iter, with a start/done handshake. Forwarding and ALU logic stay inline.

Verification
REQ-019 Forward priority: mem_rd = wb_rd = rs = 3, mem_res = 10, wb_val = 20, ADD with rd2 = 1 -> out_res = 11 after 1 cycle.
REQ-020 Zero register: rs = 0, mem_wr = 1, mem_rd = 0, mem_res = 99, rd1 = 5, ADD imm = 2 -> out_res = 7.
REQ-021 Multiply: WIDTH = 32, MULLO 0xFFFF x 0x10001 -> out_res = 0xFFFFFFFF (low word), out_valid exactly 32 cycles after accept, in_ready = 0 throughout.
REQ-022 Divide by zero: DIVU 100 / 0 -> 0xFFFFFFFF; REMU -> 100. Backpressure: out_ready = 0 for 5 cycles -> result held, no new accept.
REQ-023 Branch: rd1 = rd2 = 7, branch = 1, pc = 0x40, imm = 3 -> pc_src = flush = 1 for one cycle, br_target = 0x4C, out_wr = 0.
REQ-024 Reset mid-DIVU at cycle 10 -> after release out_valid = 0 and the unit accepts a new ADD in its first cycle.
